// File: rtl/axil_regs.sv
// axil_regs: AXI4-Lite responder exposing N_REGS byte-strobed read/write control registers
module axil_regs #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int N_REGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [ADDR_W-1:0]        araddr,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic [N_REGS*DATA_W-1:0] o_regs
);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_REGS);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("axil_regs: DATA_W must be 32");
    end

    logic [N_REGS-1:0][DATA_W-1:0] r_regs;
    logic                          r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [IDX_W-1:0]              r_aw_idx;
    logic [DATA_W-1:0]             r_wdata, r_rdata, w_rdata, w_wd;
    logic [DATA_W/8-1:0]           r_wstrb, w_ws;
    logic [1:0]                    r_bresp, r_rresp;
    logic [IDX_W-1:0]              w_widx, w_ridx;
    logic                          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wok, w_rok;
    logic                          w_unused;

    assign awready  = !r_aw_held && !r_bvalid;
    assign wready   = !r_w_held && !r_bvalid;
    assign arready  = !r_rvalid;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;
    assign o_regs   = r_regs;
    assign w_unused = ^{awaddr[1:0], araddr[1:0]};

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;
    // a write commits once both address and data are present, either held or arriving now
    assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
    assign w_widx   = r_aw_held ? r_aw_idx : awaddr[ADDR_W-1:2];
    assign w_wd     = r_w_held ? r_wdata : wdata;
    assign w_ws     = r_w_held ? r_wstrb : wstrb;
    assign w_wok    = {1'b0, w_widx} < N_LIM;
    assign w_ridx   = araddr[ADDR_W-1:2];
    assign w_rok    = {1'b0, w_ridx} < N_LIM;

    // read mux; out-of-range indices fall through to zero
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < N_REGS; k++)
            if (w_ridx == IDX_W'(k)) w_rdata = r_regs[k];
    end

    // register file, byte-strobed update on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (w_commit && w_wok) begin
            for (int k = 0; k < N_REGS; k++)
                if (w_widx == IDX_W'(k))
                    for (int b = 0; b < DATA_W/8; b++)
                        if (w_ws[b]) r_regs[k][8*b +: 8] <= w_wd[8*b +: 8];
        end
    end

    // write channel holding registers and B response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= awaddr[ADDR_W-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wok ? 2'b00 : 2'b10;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // read response, captured on AR handshake and held until R handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= w_rok ? 2'b00 : 2'b10;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_regs.sv
// tb_axil_regs: directed table-driven check of axil_regs plus multi-cycle corner sequences
module tb_axil_regs;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic [7:0]   awaddr = 0, araddr = 0;
    logic [31:0]  wdata = 0;
    logic [3:0]   wstrb = 0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] o_regs;

    int checks = 0;
    int errors = 0;

    axil_regs #(.ADDR_W(8), .DATA_W(32), .N_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .o_regs(o_regs)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_of(input int k);
        return o_regs[k*32 +: 32];
    endfunction

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while (!(aw_done && w_done) && t < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) begin aw_done = 1; awvalid = 0; end
            if (w_hs) begin w_done = 1; wvalid = 0; end
            t++;
        end
        while (!bvalid && t < 20) begin step(); t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr %0h got no bvalid", a);
        end
        resp = bresp;
        awvalid = 0; wvalid = 0;
        step();
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hs;
        int t = 0;
        araddr = a; arvalid = 1; rready = 1;
        do begin
            hs = arvalid && arready;
            step();
            t++;
        end while (!hs && t < 20);
        arvalid = 0;
        while (!rvalid && t < 20) begin step(); t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %0h got no rvalid", a);
        end
        d = rdata; resp = rresp;
        step();
    endtask

    initial begin
        logic [1:0]   resp;
        logic [31:0]  d;
        logic [127:0] snap;

        vecs[0]  = '{1, 8'h04, 32'hDEADBEEF, 4'b1111, 2'b00, 32'hDEADBEEF};
        vecs[1]  = '{0, 8'h04, 32'h0,        4'b0000, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1, 8'h00, 32'hFFFFFFFF, 4'b1111, 2'b00, 32'hFFFFFFFF};
        vecs[3]  = '{1, 8'h08, 32'h12345678, 4'b0011, 2'b00, 32'h00005678};
        vecs[4]  = '{1, 8'h0B, 32'hAABBCCDD, 4'b1100, 2'b00, 32'hAABB5678};
        vecs[5]  = '{0, 8'h08, 32'h0,        4'b0000, 2'b00, 32'hAABB5678};
        vecs[6]  = '{1, 8'h0C, 32'h7F000001, 4'b1000, 2'b00, 32'h7F000000};
        vecs[7]  = '{1, 8'h10, 32'hA5A5A5A5, 4'b1111, 2'b10, 32'h0};
        vecs[8]  = '{0, 8'h10, 32'h0,        4'b0000, 2'b10, 32'h0};
        vecs[9]  = '{0, 8'hFC, 32'h0,        4'b0000, 2'b10, 32'h0};
        vecs[10] = '{1, 8'h04, 32'h00000000, 4'b0000, 2'b00, 32'hDEADBEEF};
        vecs[11] = '{0, 8'h0C, 32'h0,        4'b0000, 2'b00, 32'h7F000000};
        vecs[12] = '{0, 8'h00, 32'h0,        4'b0000, 2'b00, 32'hFFFFFFFF};

        #2 rst_n = 0;
        #10;
        check("reset_regs", o_regs, 128'h0);
        check("reset_bvalid", bvalid, 1'b0);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_bresp", bresp, 2'b00);
        rst_n = 1;
        step();
        check("ready_after_reset", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                snap = o_regs;
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                if (vecs[i].exp_resp == 2'b10)
                    check($sformatf("vec%0d_regs_unchanged", i), o_regs, snap);
                else
                    check($sformatf("vec%0d_reg", i), reg_of(int'(vecs[i].addr[7:2])), vecs[i].exp_data);
            end else begin
                axi_read(vecs[i].addr, d, resp);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
            end
        end

        // W leads AW by three cycles; reg0 is 0xFFFFFFFF
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
        step();
        wvalid = 0;
        check("wlead_wready_low", wready, 1'b0);
        check("wlead_awready_high", awready, 1'b1);
        step();
        step();
        check("wlead_no_commit", {bvalid, reg_of(0)}, {1'b0, 32'hFFFFFFFF});
        awaddr = 8'h00; awvalid = 1;
        step();
        awvalid = 0;
        check("wlead_bvalid", bvalid, 1'b1);
        check("wlead_reg0", reg_of(0), 32'hFF22FF44);
        step();

        // bready stall: B held, second write blocked
        bready = 0;
        awaddr = 8'h04; wdata = 32'h00000001; wstrb = 4'b1111; awvalid = 1; wvalid = 1;
        step();
        check("stall_reg1", reg_of(1), 32'h00000001);
        awaddr = 8'h0C; wdata = 32'h00000033;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_b_%0d", i), {bvalid, bresp, awready, wready}, {1'b1, 2'b00, 1'b0, 1'b0});
            check($sformatf("stall_reg3_%0d", i), reg_of(3), 32'h7F000000);
            step();
        end
        bready = 1;
        step();
        check("stall_b_released", {bvalid, awready, wready}, 3'b011);
        step();
        awvalid = 0; wvalid = 0;
        check("stall_second_commit", {bvalid, reg_of(3)}, {1'b1, 32'h00000033});
        step();

        // rready stall while the read register is rewritten
        axi_write(8'h08, 32'h5, 4'b1111, resp);
        araddr = 8'h08; arvalid = 1; rready = 0;
        step();
        arvalid = 0;
        awaddr = 8'h08; wdata = 32'h9; wstrb = 4'b1111; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rstall_%0d", i), {rvalid, rdata, rresp}, {1'b1, 32'h5, 2'b00});
            step();
            awvalid = 0; wvalid = 0;
        end
        check("rstall_reg2", reg_of(2), 32'h9);
        rready = 1;
        step();
        check("rstall_released", rvalid, 1'b0);
        axi_read(8'h08, d, resp);
        check("rstall_reread", d, 32'h9);

        // reset while an address is held
        awaddr = 8'h00; awvalid = 1;
        step();
        awvalid = 0;
        check("rst_aw_held", {awready, wready}, 2'b01);
        rst_n = 0;
        #1;
        check("rst_mid_regs", o_regs, 128'h0);
        check("rst_mid_valids", {bvalid, rvalid}, 2'b00);
        step();
        rst_n = 1;
        step();
        check("rst_aw_cleared", awready, 1'b1);
        wdata = 32'hFFFFFFFF; wstrb = 4'b1111; wvalid = 1;
        step();
        wvalid = 0;
        check("rst_lone_w_held", {wready, bvalid}, 2'b00);
        step();
        step();
        check("rst_lone_w_no_commit", {bvalid, o_regs}, {1'b0, 128'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_regs.md
Name: axil_regs

Overview:
- AXI4-Lite responder (subordinate) exposing N_REGS read/write control registers to an AXI4-Lite initiator.
- It is the target end of the valid/ready channels produced by the team's initiator-side pipeline buffers.
- It accepts write address and write data independently and applies byte strobes.
- It returns write and read responses with a registered, back-pressure-safe handshake.
- Register contents are driven flat onto o_regs for use by the surrounding datapath.

Parameters:
- ADDR_W, 8: byte address width of AW/AR.
- DATA_W, 32: data width; fixed at 32 (assert otherwise).
- N_REGS, 4: number of implemented registers, 1..2^(ADDR_W-2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  ADDR_W  write byte address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response (00 OKAY, 10 SLVERR)
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  ADDR_W  read byte address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- o_regs  out  N_REGS*DATA_W  register contents, reg k at bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset (rst_n low, async):
  - all registers 0, aw_held=0, w_held=0, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0.
  - awready/wready/arready are combinational and read 1 once rst_n is released.
- Decode: index = addr[ADDR_W-1:2]; addr[1:0] ignored; index >= N_REGS is out of range.
- Write path, state = {aw_held, w_held, bvalid}:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held.
  - Commit happens on the edge where the address is available (aw_held or AW handshake this cycle) and the data is available (w_held or W handshake this cycle), with bvalid=0.
  - At commit, for each byte b with wstrb[b]=1, reg[index] byte b <= wdata byte b. Out of range: no register change, bresp=10; in range: bresp=00.
  - Also at commit: bvalid<=1 and aw_held/w_held cleared.
  - Latency: AW and W in the same cycle N -> register and o_regs updated and bvalid=1 at N+1.
  - Either channel may lead the other by any number of cycles; the second handshake cycle is N.
  - bvalid and bresp are held stable until bvalid && bready; then bvalid<=0.
  - No new AW/W is accepted while bvalid=1: one outstanding write.
- Read path, state = {rvalid}:
  - arready = !rvalid.
  - AR handshake in cycle N -> rvalid=1 at N+1, rdata = reg[index] (value before any write committing in cycle N), rresp=00.
  - Out of range: rdata=0, rresp=10.
  - rdata/rresp are held stable while rvalid && !rready; rvalid clears on the handshake edge.
  - Back-to-back reads (AR every cycle with rready=1) are not supported; maximum throughput is 1 read per 2 cycles.
- Read and write paths are fully independent; simultaneous activity on all channels is legal.
- Reset mid-transaction: held address/data is discarded, no register is updated, and all valids drop immediately.
- o_regs is a direct register output with no combinational path from any input.

Test Plan:
- Reset, then AW(0x04)+W(0xDEADBEEF, strb 1111) in cycle N, bready=1 -> bvalid=1, bresp=00 at N+1; o_regs reg1=0xDEADBEEF; AR 0x04 -> rdata 0xDEADBEEF, rresp 00.
- W(0x11223344, strb 0101) 3 cycles before AW 0x00 (reg0 previously 0xFFFFFFFF) -> wready low after W handshake; commit one cycle after AW; reg0=0xFF22FF44.
- AW 0x10 (N_REGS=4, out of range), W 0xA5A5A5A5 -> bresp=10, all regs unchanged; AR 0x10 -> rdata 0, rresp 10.
- bready held low 5 cycles after bvalid -> bvalid/bresp stable, awready=wready=0 throughout; second write is accepted only after the B handshake.
- rready low 4 cycles with reg2=0x5 while reg2 is rewritten to 0x9 -> rdata stays 0x5 until the handshake; next read returns 0x9.
- rst_n asserted while aw_held=1, w_held=0 -> after release aw_held=0, regs all 0, a subsequent lone W does not commit.
